keypad_scanner: RTL

//  Drives the 4x3 matrix keypad for the elevator access-management FSM.
//  - Scans rows, synchronises and debounces columns, encodes the pressed key.
//  - key_code output: 0-9 digits, 4'b1010 '*', 4'b1011 '#', 4'b1111 no key.
//  - Sits between the board keypad pins and the management FSM's keypad input.

---
 rtl/keypad_pkg.sv | 48 ++++
 rtl/keypad_scanner_if.sv | 18 +
 rtl/keypad_col_sync.sv | 22 ++
 rtl/keypad_scanner.sv | 128 ++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad constants, scanner state encoding and key decode helpers.
// The management FSM imports the same KEY_* codes.
package keypad_pkg;

   localparam int unsigned KP_ROWS = 4;
   localparam int unsigned KP_COLS = 3;

   localparam logic [3:0] KEY_NONE = 4'hF;
   localparam logic [3:0] KEY_STAR = 4'hA;
   localparam logic [3:0] KEY_HASH = 4'hB;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } kp_state_e;

   // Rows 0-2 hold digits 1-9 in reading order; row 3 is * 0 #.
   function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = KEY_NONE;
      if (row == 2'd3) begin
         case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'd0;
            default: code = KEY_HASH;
         endcase
      end else begin
         code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
      end
      return code;
   endfunction

   // Lowest-index active-low column; caller guarantees at least one is active.
   function automatic logic [1:0] lowest_col(input logic [2:0] col_s);
      logic [1:0] idx;
      idx = 2'd2;
      if (!col_s[0])      idx = 2'd0;
      else if (!col_s[1]) idx = 2'd1;
      return idx;
   endfunction

   function automatic logic [3:0] row_drive(input logic [1:0] row);
      return ~(4'b0001 << row);
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin side and decoded-key side of the scanner, bundled as one port.
interface keypad_scanner_if;
   logic [2:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_strobe;

   modport master (
      input  col_n,
      output row_n, key_code, key_valid, key_strobe
   );

   modport slave (
      output col_n,
      input  row_n, key_code, key_valid, key_strobe
   );
endinterface

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous active-low column inputs.
module keypad_col_sync (
   input  logic       clk,
   input  logic       RST,
   input  logic [2:0] col_n_i,
   output logic [2:0] col_s_o
);
   logic [2:0] meta_q;
   logic [2:0] sync_q;

   always_ff @(posedge clk) begin
      if (RST) begin
         meta_q <= 3'b111;
         sync_q <= 3'b111;
      end else begin
         meta_q <= col_n_i;
         sync_q <= meta_q;
      end
   end

   assign col_s_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: row scan, column debounce, key encode with press strobe.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CYC = 20000
) (
   input  logic        clk,
   input  logic        RST,
   keypad_scanner_if.master kp
);
   localparam int unsigned DIV_W = $clog2(SCAN_DIV);
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYC);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

   kp_state_e        state_q;
   logic [DIV_W-1:0] div_cnt_q;
   logic [DEB_W-1:0] deb_cnt_q;
   logic [1:0]       row_q;
   logic [1:0]       col_q;
   logic [3:0]       row_n_q;
   logic [3:0]       key_code_q;
   logic             key_valid_q;
   logic             key_strobe_q;

   logic [2:0]       col_s;
   logic [1:0]       row_nxt_c;
   logic             col_hit_c;

   keypad_col_sync u_col_sync (
      .clk     (clk),
      .RST     (RST),
      .col_n_i (kp.col_n),
      .col_s_o (col_s)
   );

   assign row_nxt_c = row_q + 2'd1;

   always_comb begin
      col_hit_c = 1'b0;
      case (col_q)
         2'd0:    col_hit_c = ~col_s[0];
         2'd1:    col_hit_c = ~col_s[1];
         default: col_hit_c = ~col_s[2];
      endcase
   end

   // Every state change clears the counters, so they never need to saturate.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q      <= ST_SCAN;
         div_cnt_q    <= '0;
         deb_cnt_q    <= '0;
         row_q        <= 2'd0;
         col_q        <= 2'd0;
         row_n_q      <= 4'b1110;
         key_code_q   <= KEY_NONE;
         key_valid_q  <= 1'b0;
         key_strobe_q <= 1'b0;
      end else begin
         key_strobe_q <= 1'b0;
         case (state_q)
            ST_SCAN: begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_q <= '0;
                  if (col_s != 3'b111) begin
                     col_q     <= lowest_col(col_s);
                     deb_cnt_q <= '0;
                     state_q   <= ST_DEBOUNCE;
                  end else begin
                     row_q   <= row_nxt_c;
                     row_n_q <= row_drive(row_nxt_c);
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + DIV_W'(1);
               end
            end
            ST_DEBOUNCE: begin
               if (!col_hit_c) begin
                  state_q   <= ST_SCAN;
                  div_cnt_q <= '0;
                  deb_cnt_q <= '0;
                  row_q     <= row_nxt_c;
                  row_n_q   <= row_drive(row_nxt_c);
               end else if (deb_cnt_q == DEB_LAST) begin
                  state_q      <= ST_PRESSED;
                  deb_cnt_q    <= '0;
                  key_code_q   <= key_decode(row_q, col_q);
                  key_valid_q  <= 1'b1;
                  key_strobe_q <= 1'b1;
               end else begin
                  deb_cnt_q <= deb_cnt_q + DEB_W'(1);
               end
            end
            ST_PRESSED: begin
               if (!col_hit_c) begin
                  state_q   <= ST_RELEASE;
                  deb_cnt_q <= '0;
               end
            end
            ST_RELEASE: begin
               // A contact returning mid-release resumes the held key silently.
               if (col_hit_c) begin
                  state_q   <= ST_PRESSED;
                  deb_cnt_q <= '0;
               end else if (deb_cnt_q == DEB_LAST) begin
                  state_q     <= ST_SCAN;
                  div_cnt_q   <= '0;
                  deb_cnt_q   <= '0;
                  key_code_q  <= KEY_NONE;
                  key_valid_q <= 1'b0;
                  row_q       <= row_nxt_c;
                  row_n_q     <= row_drive(row_nxt_c);
               end else begin
                  deb_cnt_q <= deb_cnt_q + DEB_W'(1);
               end
            end
            default: state_q <= ST_SCAN;
         endcase
      end
   end

   assign kp.row_n      = row_n_q;
   assign kp.key_code   = key_code_q;
   assign kp.key_valid  = key_valid_q;
   assign kp.key_strobe = key_strobe_q;
endmodule
